slot_alloc: RTL and testbench

Bitmap slot allocator: tracks `2**ORDER` slots and offers the lowest-numbered free slot through a take handshake. It accepts slot releases by index. It is the index-to-bitmap counterpart of the trailing-zero search logic: allocation encodes a free bitmap into an index, and release decodes an index back into a one-hot clear mask. It sits between request sources (tag/ID generators, buffer-slot managers) and consumers that return indices when done.

---
 rtl/slot_alloc_pkg.sv | 29 ++
 rtl/slot_alloc_if.sv | 42 ++++
 rtl/slot_alloc_onehot_dec.sv | 24 ++
 rtl/slot_alloc.sv | 119 +++++++++++
 tb/tb_slot_alloc.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/slot_alloc_pkg.sv
// ---------------------------------------------------------------------------
// slot_alloc_pkg
//   Shared definitions for the bitmap slot allocator:
//     - DEF_ORDER    : default log2 of the slot count
//     - slotCount()  : number of slots W = 2**ORDER
//     - countWidth() : width of the allocated-slot counter (ORDER+1, holds 0..W)
//     - RST_*        : reset values of the allocator state
// ---------------------------------------------------------------------------
package slot_alloc_pkg;

    localparam int DEF_ORDER = 3;

    // Reset values: every slot free, nothing counted, no pending error pulse.
    localparam logic RST_BUSY_BIT = 1'b0;
    localparam int   RST_COUNT    = 0;
    localparam logic RST_FREE_ERR = 1'b0;

    // Number of slots tracked for a given order.
    function automatic int slotCount(input int order);
        return 1 << order;
    endfunction

    // The counter must hold the value W itself, so it needs one bit more
    // than a slot index.
    function automatic int countWidth(input int order);
        return order + 1;
    endfunction

endpackage

// File: rtl/slot_alloc_if.sv
// ---------------------------------------------------------------------------
// slot_alloc_if
//   Groups the allocator's offer/take, release, flush and status signals.
//   slave  : allocator side (drives offer and status, receives requests)
//   master : client side (drives take/release/flush, observes offer/status)
//   Signals:
//     alloc_valid, alloc_idx  offer of the lowest free slot
//     alloc_take              consumer accepts the offered slot
//     free_valid, free_idx    release of a slot by index
//     flush                   synchronous clear of all allocations
//     free_err                one-cycle pulse after a release of a free slot
//     count, full, empty      occupancy status
// ---------------------------------------------------------------------------
interface slot_alloc_if
    import slot_alloc_pkg::*;
#(
    parameter int ORDER = DEF_ORDER
);
    localparam int CW = countWidth(ORDER);

    logic             alloc_valid;
    logic [ORDER-1:0] alloc_idx;
    logic             alloc_take;
    logic             free_valid;
    logic [ORDER-1:0] free_idx;
    logic             flush;
    logic             free_err;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    modport slave (
        output alloc_valid, alloc_idx, free_err, count, full, empty,
        input  alloc_take, free_valid, free_idx, flush
    );

    modport master (
        input  alloc_valid, alloc_idx, free_err, count, full, empty,
        output alloc_take, free_valid, free_idx, flush
    );

endinterface

// File: rtl/slot_alloc_onehot_dec.sv
// ---------------------------------------------------------------------------
// onehot_dec
//   Binary index to one-hot decoder. The allocator uses one instance to
//   build the set mask for a take and another for the clear mask of a release.
//   Ports:
//     idx_i     binary index, ORDER bits
//     onehot_o  2**ORDER-bit one-hot vector with bit idx_i set
// ---------------------------------------------------------------------------
module onehot_dec
    import slot_alloc_pkg::*;
#(
    parameter int ORDER = DEF_ORDER
) (
    input  logic [ORDER-1:0]            idx_i,
    output logic [slotCount(ORDER)-1:0] onehot_o
);

    // Start from all zeros and raise exactly the addressed bit.
    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/slot_alloc.sv
// ---------------------------------------------------------------------------
// slot_alloc
//   Bitmap slot allocator. Keeps a busy bitmap of W = 2**ORDER slots, offers
//   the lowest free slot combinationally, sets it on a take, clears a slot on
//   a release, and flags releases of slots that were already free.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    slot_alloc_if.slave (offer/take, release, flush, status)
// ---------------------------------------------------------------------------
module slot_alloc
    import slot_alloc_pkg::*;
#(
    parameter int ORDER = DEF_ORDER
) (
    input  logic        clk,
    input  logic        rst_n,
    slot_alloc_if.slave bus
);

    localparam int W  = slotCount(ORDER);
    localparam int CW = countWidth(ORDER);

    logic [W-1:0]     busy_q, busy_d;
    logic [CW-1:0]    count_q, count_d;
    logic             free_err_q, free_err_d;

    logic [W-1:0]     freeBits;
    logic             anyFree;
    logic [ORDER-1:0] lowIdx;
    logic [W-1:0]     takeMask;
    logic [W-1:0]     freeMask;
    logic             freeHit;
    logic             takeEff;
    logic             freeEff;
    logic             dblFree;

    assign freeBits = ~busy_q;

    // Trailing-zero search over the free bitmap. Scanning from the top down
    // lets the last hit win, which leaves the lowest free slot in lowIdx.
    // With nothing free the index stays at 0.
    always_comb begin
        anyFree = |freeBits;
        lowIdx  = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (freeBits[i]) begin
                lowIdx = ORDER'(i);
            end
        end
    end

    onehot_dec #(.ORDER(ORDER)) u_take_dec (
        .idx_i    (lowIdx),
        .onehot_o (takeMask)
    );

    onehot_dec #(.ORDER(ORDER)) u_free_dec (
        .idx_i    (bus.free_idx),
        .onehot_o (freeMask)
    );

    // A release only counts if the slot is currently busy. When it names the
    // slot being taken this same cycle, that slot is still free in busy_q,
    // so the release is reported as a double free while the take proceeds.
    assign freeHit = |(busy_q & freeMask);
    assign takeEff = anyFree & bus.alloc_take;
    assign freeEff = bus.free_valid & freeHit;
    assign dblFree = bus.free_valid & ~freeHit;

    // Next-state: flush overrides everything; otherwise apply take and
    // release masks together. They can never address the same slot, since a
    // take targets a free slot and an effective release targets a busy one.
    always_comb begin
        busy_d     = busy_q;
        count_d    = count_q;
        free_err_d = 1'b0;
        if (bus.flush) begin
            busy_d     = {W{RST_BUSY_BIT}};
            count_d    = CW'(RST_COUNT);
            free_err_d = RST_FREE_ERR;
        end else begin
            if (takeEff) begin
                busy_d = busy_d | takeMask;
            end
            if (freeEff) begin
                busy_d = busy_d & ~freeMask;
            end
            unique case ({takeEff, freeEff})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            free_err_d = dblFree;
        end
    end

    // State registers with asynchronous reset to the all-free state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= {W{RST_BUSY_BIT}};
            count_q    <= CW'(RST_COUNT);
            free_err_q <= RST_FREE_ERR;
        end else begin
            busy_q     <= busy_d;
            count_q    <= count_d;
            free_err_q <= free_err_d;
        end
    end

    // Offer comes straight from the registered bitmap; status from count_q.
    assign bus.alloc_valid = anyFree;
    assign bus.alloc_idx   = lowIdx;
    assign bus.free_err    = free_err_q;
    assign bus.count       = count_q;
    assign bus.full        = (count_q == CW'(W));
    assign bus.empty       = (count_q == '0);

endmodule

// File: tb/tb_slot_alloc.sv
// ---------------------------------------------------------------------------
// tb_slot_alloc
//   Drives slot_alloc (ORDER=3) through directed scenarios and a randomized
//   phase. A reference model built from an array of per-slot flags predicts
//   the offer and status for each cycle; predictions are queued and a
//   separate monitor compares them with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_slot_alloc;

    localparam int ORDER = 3;
    localparam int W     = 8;

    typedef struct {
        string    tag;
        bit       av;
        int       idx;
        bit       err;
        int       cnt;
        bit       full;
        bit       empty;
    } exp_t;

    logic clk;
    logic rst_n;

    slot_alloc_if #(.ORDER(ORDER)) bus ();

    slot_alloc #(.ORDER(ORDER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t expQ[$];
    event sampleEv;
    int   vectors;
    int   miscompares;

    // Reference model state: which slots are held, and whether the previous
    // cycle attempted to release a slot that was not held.
    bit   mBusy[W];
    bit   mErr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mLowest();
        for (int i = 0; i < W; i++) begin
            if (!mBusy[i]) return i;
        end
        return -1;
    endfunction

    function automatic int mCount();
        int n = 0;
        for (int i = 0; i < W; i++) n += mBusy[i];
        return n;
    endfunction

    task automatic mClear();
        for (int i = 0; i < W; i++) mBusy[i] = 1'b0;
        mErr = 1'b0;
    endtask

    // Predict what the DUT should show right now and hand it to the monitor.
    task automatic pushExpect(input string tag);
        exp_t e;
        int   low;
        low     = mLowest();
        e.tag   = tag;
        e.av    = (low >= 0);
        e.idx   = (low >= 0) ? low : 0;
        e.err   = mErr;
        e.cnt   = mCount();
        e.full  = (mCount() == W);
        e.empty = (mCount() == 0);
        expQ.push_back(e);
        -> sampleEv;
    endtask

    task automatic checkOutput(input string tag, input string field,
                               input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s.%s actual=%0d expected=%0d at %0t",
                     tag, field, act, exp, $time);
        end
    endtask

    // Monitor: every time a prediction is published, sample the DUT a little
    // later (away from both clock edges) and compare field by field.
    initial begin
        exp_t e;
        forever begin
            @(sampleEv);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput(e.tag, "alloc_valid", int'(bus.alloc_valid), int'(e.av));
                if (e.av) checkOutput(e.tag, "alloc_idx", int'(bus.alloc_idx), e.idx);
                else      checkOutput(e.tag, "alloc_idx_idle", int'(bus.alloc_idx), 0);
                checkOutput(e.tag, "free_err", int'(bus.free_err), int'(e.err));
                checkOutput(e.tag, "count", int'(bus.count), e.cnt);
                checkOutput(e.tag, "full", int'(bus.full), int'(e.full));
                checkOutput(e.tag, "empty", int'(bus.empty), int'(e.empty));
            end
        end
    end

    // One clock cycle: publish the prediction for the current state, drive
    // the requests, then advance the model by the rules for this cycle.
    task automatic applyStimulus(input bit take, input bit fv, input int fidx,
                                 input bit fl, input string tag);
        int low;
        bit wasBusy;
        @(negedge clk);
        pushExpect(tag);
        bus.alloc_take = take;
        bus.free_valid = fv;
        bus.free_idx   = fidx[ORDER-1:0];
        bus.flush      = fl;
        low     = mLowest();
        wasBusy = mBusy[fidx];
        if (fl) begin
            mClear();
        end else begin
            if (take && low >= 0) mBusy[low] = 1'b1;
            if (fv && wasBusy) mBusy[fidx] = 1'b0;
            mErr = fv && !wasBusy;
        end
        @(posedge clk);
    endtask

    // Reset pulse placed between clock edges; outputs must drop to reset
    // values without waiting for a clock.
    task automatic midReset();
        @(negedge clk);
        bus.alloc_take = 1'b0;
        bus.free_valid = 1'b0;
        bus.flush      = 1'b0;
        #2;
        rst_n = 1'b0;
        mClear();
        pushExpect("mid_reset");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int  r;
        bit  take, fv, fl;
        int  fidx;
        vectors     = 0;
        miscompares = 0;
        mClear();
        rst_n          = 1'b0;
        bus.alloc_take = 1'b0;
        bus.free_valid = 1'b0;
        bus.free_idx   = '0;
        bus.flush      = 1'b0;
        repeat (2) @(negedge clk);
        pushExpect("reset");
        #2;
        rst_n = 1'b1;

        // Fill all eight slots, then a ninth take that must be ignored.
        for (int i = 0; i < W; i++) applyStimulus(1, 0, 0, 0, "fill");
        applyStimulus(1, 0, 0, 0, "take_when_full");
        applyStimulus(0, 0, 0, 0, "still_full");

        // Release slot 3 from full, retake it.
        applyStimulus(0, 1, 3, 0, "free3");
        applyStimulus(1, 0, 0, 0, "retake3");
        applyStimulus(0, 0, 0, 0, "full_again");

        // Slots 0-4 busy, release free slot 5.
        applyStimulus(0, 0, 0, 1, "flush1");
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, "fill5");
        applyStimulus(0, 1, 5, 0, "double_free");
        applyStimulus(0, 0, 0, 0, "err_pulse");
        applyStimulus(0, 0, 0, 0, "err_gone");

        // Take slot 5 while releasing slot 1.
        applyStimulus(1, 1, 1, 0, "take_and_free");
        applyStimulus(0, 0, 0, 0, "after_swap");

        // Take and release of the offered slot in the same cycle.
        applyStimulus(1, 1, 1, 0, "take_free_same");
        applyStimulus(0, 0, 0, 0, "after_same");

        // Slots 0-5 busy, flush with take and release asserted.
        applyStimulus(0, 0, 0, 1, "flush2");
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, "fill6");
        applyStimulus(1, 1, 2, 1, "flush_priority");
        applyStimulus(0, 0, 0, 0, "after_flush");

        // Four slots busy, asynchronous reset, then take slot 0 again.
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, "fill4");
        midReset();
        applyStimulus(1, 0, 0, 0, "take_after_reset");
        applyStimulus(0, 0, 0, 0, "after_reset_take");

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            r    = int'($urandom_range(0, 99));
            take = (r < 60);
            fv   = ($urandom_range(0, 99) < 45);
            fidx = int'($urandom_range(0, W - 1));
            fl   = ($urandom_range(0, 99) < 3);
            applyStimulus(take, fv, fidx, fl, "random");
        end

        @(negedge clk);
        bus.alloc_take = 1'b0;
        bus.free_valid = 1'b0;
        bus.flush      = 1'b0;
        pushExpect("final");
        for (int t = 0; t < 5 && expQ.size() != 0; t++) @(posedge clk);
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
